fnd_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the multi-digit common-anode FND display.

---
 rtl/fnd_scan_ctrl_pkg.sv | 15 +
 rtl/fnd_scan_ctrl_bin2fnd.sv | 31 +++
 rtl/fnd_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared definitions for the FND scan controller: FSM states and the
// font/select constants that mean "dark".
package fnd_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_t;

  localparam logic [7:0] FONT_BLANK  = 8'hff;
  localparam int         FONT_DP_BIT = 7;
  localparam logic       SEL_OFF     = 1'b1;

endpackage

// File: rtl/fnd_scan_ctrl_bin2fnd.sv
// 4-bit value to common-anode seven-segment pattern {dp,g..a}, active-low.
// The dp bit is always returned dark; the caller decides whether to light it.
module fnd_scan_ctrl_bin2fnd (
  input  logic [3:0] bin,
  output logic [7:0] font
);

  always_comb begin
    font = 8'hff;
    case (bin)
      4'h0: font = 8'hc0;
      4'h1: font = 8'hf9;
      4'h2: font = 8'ha4;
      4'h3: font = 8'hb0;
      4'h4: font = 8'h99;
      4'h5: font = 8'h92;
      4'h6: font = 8'h82;
      4'h7: font = 8'hf8;
      4'h8: font = 8'h80;
      4'h9: font = 8'h90;
      4'ha: font = 8'h88;
      4'hb: font = 8'h83;
      4'hc: font = 8'hc6;
      4'hd: font = 8'ha1;
      4'he: font = 8'h86;
      4'hf: font = 8'h8e;
      default: font = 8'hff;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan of a DIGITS-wide FND display through one shared decoder,
// with a per-frame input snapshot and an all-off gap between digit slots.
module fnd_scan_ctrl
  import fnd_scan_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dpMask,
  input  logic                  i_lzBlank,
  output logic [DIGITS-1:0]     o_fndSel,
  output logic [7:0]            o_fndFont,
  output logic                  o_frameTick
);

  localparam int PERIOD   = CLK_HZ / SCAN_HZ;
  localparam int SHOW_LEN = PERIOD - BLANK_CYCLES;
  localparam int IDX_W    = $clog2(DIGITS);
  localparam int CNT_W    = $clog2(PERIOD);

  scan_state_t          state, nxt_state;
  logic [IDX_W-1:0]     idx, nxt_idx;
  logic [CNT_W-1:0]     cnt, nxt_cnt;
  logic [4*DIGITS-1:0]  snap_value, nxt_value;
  logic [DIGITS-1:0]    snap_dp, nxt_dp;
  logic                 snap_lz, nxt_lz;
  logic                 take_snap;
  logic                 upper_zero;
  logic                 digit_blank;
  logic [3:0]           nibble;
  logic [7:0]           raw_font;
  logic [7:0]           show_font;

  // Outputs are registered from the next-state view, so the font of the
  // first digit already uses the snapshot being captured on that same edge.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    take_snap = 1'b0;
    if (!i_en) begin
      nxt_state = ST_IDLE;
      nxt_idx   = '0;
      nxt_cnt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          nxt_state = ST_SHOW;
          nxt_idx   = '0;
          nxt_cnt   = '0;
          take_snap = 1'b1;
        end
        ST_SHOW: begin
          if (cnt == CNT_W'(SHOW_LEN - 1)) begin
            nxt_state = ST_GAP;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            nxt_state = ST_SHOW;
            nxt_cnt   = '0;
            if (idx == IDX_W'(DIGITS - 1)) begin
              nxt_idx   = '0;
              take_snap = 1'b1;
            end else begin
              nxt_idx = idx + IDX_W'(1);
            end
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_idx   = '0;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  assign nxt_value = take_snap ? i_value   : snap_value;
  assign nxt_dp    = take_snap ? i_dpMask  : snap_dp;
  assign nxt_lz    = take_snap ? i_lzBlank : snap_lz;
  assign nibble    = nxt_value[{nxt_idx, 2'b00} +: 4];

  fnd_scan_ctrl_bin2fnd u_bin2fnd (
    .bin  (nibble),
    .font (raw_font)
  );

  // A digit is a leading zero when it and everything above it are zero;
  // digit 0 always shows and a lit dp keeps its own digit visible.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(nxt_idx) && nxt_value[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
    digit_blank = nxt_lz && (nxt_idx != '0) && upper_zero && !nxt_dp[nxt_idx];
    show_font   = raw_font;
    if (nxt_dp[nxt_idx]) show_font[FONT_DP_BIT] = 1'b0;
    if (digit_blank) show_font = FONT_BLANK;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      snap_value  <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
      o_fndSel    <= {DIGITS{SEL_OFF}};
      o_fndFont   <= FONT_BLANK;
      o_frameTick <= 1'b0;
    end else begin
      state       <= nxt_state;
      idx         <= nxt_idx;
      cnt         <= nxt_cnt;
      snap_value  <= nxt_value;
      snap_dp     <= nxt_dp;
      snap_lz     <= nxt_lz;
      o_fndSel    <= (nxt_state == ST_SHOW) ? ~(DIGITS'(1) << nxt_idx) : {DIGITS{SEL_OFF}};
      o_fndFont   <= (nxt_state == ST_SHOW) ? show_font : FONT_BLANK;
      o_frameTick <= take_snap;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: directed cases with literal expectations plus a
// randomized run, all outputs compared every cycle against a frame-position model.
module tb_fnd_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int PERIOD = 10;
  localparam int SHOW   = 8;
  localparam int FRAME  = DIGITS * PERIOD;

  localparam logic [7:0] SEG [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  sel;
  logic [7:0]  font;
  logic        tick;

  int total = 0;
  int bad   = 0;

  fnd_scan_ctrl #(
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .DIGITS       (DIGITS),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_en        (en),
    .i_value     (value),
    .i_dpMask    (dp_mask),
    .i_lzBlank   (lz_blank),
    .o_fndSel    (sel),
    .o_fndFont   (font),
    .o_frameTick (tick)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Model: an enabled display is just a position within a 40-cycle frame.
  bit          m_active = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_value = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lz = 1'b0;
  logic [3:0]  exp_sel = 4'hf;
  logic [7:0]  exp_font = 8'hff;
  logic        exp_tick = 1'b0;

  function automatic int next_pos(input bit active, input int pos);
    return active ? (pos + 1) % FRAME : 0;
  endfunction

  function automatic logic [7:0] model_font(input logic [15:0] v, input logic [3:0] dp,
                                            input logic lz, input int slot);
    int upper = int'(v) >> (4 * slot);
    logic [7:0] f = SEG[upper % 16];
    if (dp[slot]) f = f & 8'h7f;
    if (lz && slot > 0 && upper == 0 && !dp[slot]) f = 8'hff;
    return f;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || !en) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      exp_sel  <= 4'hf;
      exp_font <= 8'hff;
      exp_tick <= 1'b0;
      if (rst) begin
        m_value <= '0;
        m_dp    <= '0;
        m_lz    <= 1'b0;
      end
    end else begin
      m_active <= 1'b1;
      m_pos    <= next_pos(m_active, m_pos);
      exp_tick <= (next_pos(m_active, m_pos) == 0);
      if (next_pos(m_active, m_pos) == 0) begin
        m_value <= value;
        m_dp    <= dp_mask;
        m_lz    <= lz_blank;
      end
      if (next_pos(m_active, m_pos) % PERIOD < SHOW) begin
        exp_sel  <= 4'hf & ~(4'b1 << (next_pos(m_active, m_pos) / PERIOD));
        exp_font <= (next_pos(m_active, m_pos) == 0)
                    ? model_font(value, dp_mask, lz_blank, 0)
                    : model_font(m_value, m_dp, m_lz, next_pos(m_active, m_pos) / PERIOD);
      end else begin
        exp_sel  <= 4'hf;
        exp_font <= 8'hff;
      end
    end
  end

  always @(negedge clk) begin
    check_output("sel", int'(sel), int'(exp_sel));
    check_output("font", int'(font), int'(exp_font));
    check_output("tick", int'(tick), int'(exp_tick));
    check_output("overlap", int'($countones(~sel) <= 1), 1);
  end

  task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    en = 1'b0;
    @(negedge clk);
    value    = v;
    dp_mask  = dp;
    lz_blank = lz;
    en       = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_lit(input string name, input logic [3:0] s, input logic [7:0] f);
    check_output({name, "_sel"}, int'(sel), int'(s));
    check_output({name, "_font"}, int'(font), int'(f));
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_lit("reset", 4'hf, 8'hff);
    check_output("reset_tick", int'(tick), 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_lit("idle", 4'hf, 8'hff);

    // basic scan of 1234, then a mid-frame change that must not tear
    value = 16'h1234;
    en    = 1'b1;
    @(negedge clk);
    check_lit("scan_d0", 4'b1110, 8'h99);
    check_output("scan_tick", int'(tick), 1);
    repeat (8) @(negedge clk);
    check_lit("scan_gap", 4'hf, 8'hff);
    repeat (2) @(negedge clk);
    check_lit("scan_d1", 4'b1101, 8'hb0);
    check_output("scan_tick_mid", int'(tick), 0);
    repeat (10) @(negedge clk);
    check_lit("scan_d2", 4'b1011, 8'ha4);
    repeat (3) @(negedge clk);
    value = 16'hABCD;
    repeat (7) @(negedge clk);
    check_lit("snap_d3", 4'b0111, 8'hf9);
    repeat (10) @(negedge clk);
    check_lit("snap_next_d0", 4'b1110, 8'ha1);
    check_output("snap_tick", int'(tick), 1);
    repeat (10) @(negedge clk);
    check_lit("snap_next_d1", 4'b1101, 8'hc6);

    // leading-zero blanking
    apply_stimulus(16'h0005, 4'b0000, 1'b1);
    check_lit("lz_d0", 4'b1110, 8'h92);
    repeat (10) @(negedge clk);
    check_lit("lz_d1", 4'b1101, 8'hff);
    repeat (20) @(negedge clk);
    check_lit("lz_d3", 4'b0111, 8'hff);
    apply_stimulus(16'h0000, 4'b0000, 1'b1);
    check_lit("lz_zero", 4'b1110, 8'hc0);

    // decimal points
    apply_stimulus(16'h0012, 4'b0010, 1'b1);
    repeat (10) @(negedge clk);
    check_lit("dp_d1", 4'b1101, 8'h79);
    apply_stimulus(16'h0012, 4'b0100, 1'b1);
    repeat (20) @(negedge clk);
    check_lit("dp_d2", 4'b1011, 8'h40);

    // disable mid-slot, re-enable, async reset mid-slot
    apply_stimulus(16'h1234, 4'b0000, 1'b0);
    repeat (21) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_lit("dis_dark", 4'hf, 8'hff);
    en = 1'b1;
    @(negedge clk);
    check_lit("reen_d0", 4'b1110, 8'h99);
    check_output("reen_tick", int'(tick), 1);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_lit("async_rst", 4'hf, 8'hff);
    @(negedge clk);
    rst = 1'b0;

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) value = 16'($urandom);
      if ($urandom_range(15) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(31) == 0) lz_blank = 1'($urandom);
      if (en && $urandom_range(199) == 0) en = 1'b0;
      else if (!en && $urandom_range(3) == 0) en = 1'b1;
      if ($urandom_range(999) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
